npc_ctrl: RTL and testbench

Fetch-side next-PC controller for the five-stage RISC-V pipeline. It consumes the 2-bit `npc_sel` decision and `br_type` from the EX-stage branch unit and owns the architectural fetch PC. Each cycle it selects the next PC from sequential, branch-taken or jump targets, generates IF/ID and ID/EX flush pulses on redirect, and traps on misaligned targets. It also keeps branch/jump performance counters.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/perf_cnt.sv | 17 +
 rtl/npc_ctrl.sv | 106 ++++++++++
 tb/tb_npc_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: control-transfer types, next-PC select, fetch FSM state.
package cpu_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0040_0000;

  // br_type encodings carried down the pipe from decode
  localparam logic [3:0] BR_BEQ  = 4'b0000;
  localparam logic [3:0] BR_BNE  = 4'b0001;
  localparam logic [3:0] BR_JAL  = 4'b0010;
  localparam logic [3:0] BR_JALR = 4'b0011;
  localparam logic [3:0] BR_BLT  = 4'b0100;
  localparam logic [3:0] BR_BGE  = 4'b0101;
  localparam logic [3:0] BR_BLTU = 4'b0110;
  localparam logic [3:0] BR_BGEU = 4'b0111;

  // next-PC decision from the branch unit; 11 is unused and behaves as sequential
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_JMP = 2'b10,
    NPC_RSV = 2'b11
  } npc_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } npc_state_e;

  // conditional branches: beq/bne/blt/bge/bltu/bgeu
  function automatic logic is_cond_br(input logic [3:0] br);
    return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_BLT) ||
           (br == BR_BGE) || (br == BR_BLTU) || (br == BR_BGEU);
  endfunction

  // unconditional jumps: jal/jalr
  function automatic logic is_jump(input logic [3:0] br);
    return (br == BR_JAL) || (br == BR_JALR);
  endfunction

endpackage

// File: rtl/perf_cnt.sv
// Enable-gated wrapping event counter with synchronous reset.
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // count one event per enabled cycle; wraps naturally at all-ones
  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/npc_ctrl.sv
// Fetch-side next-PC controller: owns the fetch PC, redirects on EX-stage
// branches/jumps, flushes IF/ID and ID/EX on redirect, traps on misaligned targets.
module npc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        valid_ex,
  input  logic [1:0]  npc_sel_ex,
  input  logic [3:0]  br_type_ex,
  input  logic [31:0] pc_ex,
  input  logic [31:0] imm_ex,
  input  logic [31:0] alu_res_ex,
  output logic [31:0] pc_if,
  output logic [31:0] pc_add4_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        halt,
  output logic [31:0] bad_target,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_taken,
  output logic [31:0] cnt_jump
);

  npc_state_e  state, state_nxt;
  logic [31:0] target;
  logic        redirect, misaligned, running, cnt_ok;
  logic [31:0] pc_nxt, bad_nxt;

  assign running    = (state == RUN);
  assign pc_add4_if = pc_if + 32'd4;

  // jalr target comes from the ALU with bit0 cleared; everything else is pc+imm
  assign target = ((npc_sel_ex == NPC_JMP) && (br_type_ex == BR_JALR))
                  ? (alu_res_ex & ~32'h1) : (pc_ex + imm_ex);
  assign misaligned = (target[1:0] != 2'b00);

  // rst gates the redirect so no flush escapes during a reset cycle
  assign redirect = valid_ex & running & ~rst &
                    ((npc_sel_ex == NPC_BR) | (npc_sel_ex == NPC_JMP));
  assign flush_id = redirect;
  assign flush_ex = redirect;
  assign halt     = (state == HALT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // next state: a misaligned redirect traps; only reset leaves HALT
  always_comb begin
    state_nxt = state;
    if (running && redirect && misaligned) state_nxt = HALT;
  end

  // next PC / trap address: redirect beats stall, stall beats sequential
  always_comb begin
    pc_nxt  = pc_if;
    bad_nxt = bad_target;
    if (running) begin
      if (redirect && misaligned) bad_nxt = target;
      else if (redirect)          pc_nxt  = target;
      else if (!stall_pc)         pc_nxt  = pc_add4_if;
    end
  end

  // fetch PC and trap address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if      <= PC_RESET;
      bad_target <= '0;
    end else begin
      pc_if      <= pc_nxt;
      bad_target <= bad_nxt;
    end
  end

  // counters see every real EX instruction while running, stalled or not
  assign cnt_ok = valid_ex & running;

  perf_cnt #(.W(32)) u_cnt_branch (
    .clk (clk),
    .rst (rst),
    .en  (cnt_ok & is_cond_br(br_type_ex)),
    .cnt (cnt_branch)
  );

  perf_cnt #(.W(32)) u_cnt_taken (
    .clk (clk),
    .rst (rst),
    .en  (cnt_ok & is_cond_br(br_type_ex) & (npc_sel_ex == NPC_BR)),
    .cnt (cnt_taken)
  );

  perf_cnt #(.W(32)) u_cnt_jump (
    .clk (clk),
    .rst (rst),
    .en  (cnt_ok & is_jump(br_type_ex)),
    .cnt (cnt_jump)
  );

endmodule

// File: tb/tb_npc_ctrl.sv
// Directed bench for npc_ctrl: a driver issues one vector per cycle and queues
// the hand-computed expected outputs; a monitor pops and compares each cycle.
module tb_npc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall_pc, valid_ex;
  logic [1:0]  npc_sel_ex;
  logic [3:0]  br_type_ex;
  logic [31:0] pc_ex, imm_ex, alu_res_ex;
  logic [31:0] pc_if, pc_add4_if, bad_target, cnt_branch, cnt_taken, cnt_jump;
  logic        flush_id, flush_ex, halt;
  logic        sc_en;
  logic [3:0]  sc_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        hlt;
    logic [31:0] bad;
    logic [31:0] cb, ct, cj;
    logic [3:0]  sc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_n = 0;

  always #5 clk = ~clk;

  npc_ctrl #(.PC_RESET(32'h0040_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_pc   (stall_pc),
    .valid_ex   (valid_ex),
    .npc_sel_ex (npc_sel_ex),
    .br_type_ex (br_type_ex),
    .pc_ex      (pc_ex),
    .imm_ex     (imm_ex),
    .alu_res_ex (alu_res_ex),
    .pc_if      (pc_if),
    .pc_add4_if (pc_add4_if),
    .flush_id   (flush_id),
    .flush_ex   (flush_ex),
    .halt       (halt),
    .bad_target (bad_target),
    .cnt_branch (cnt_branch),
    .cnt_taken  (cnt_taken),
    .cnt_jump   (cnt_jump)
  );

  // narrow counter instance so the wrap to zero is reachable in a short run
  perf_cnt #(.W(4)) u_small (
    .clk (clk),
    .rst (rst),
    .en  (sc_en),
    .cnt (sc_cnt)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_if",      e.cyc, pc_if,      e.pc);
      chk("pc_add4_if", e.cyc, pc_add4_if, e.pc + 32'd4);
      chk("flush_id",   e.cyc, {31'd0, flush_id}, {31'd0, e.fl});
      chk("flush_ex",   e.cyc, {31'd0, flush_ex}, {31'd0, e.fl});
      chk("halt",       e.cyc, {31'd0, halt},     {31'd0, e.hlt});
      chk("bad_target", e.cyc, bad_target, e.bad);
      chk("cnt_branch", e.cyc, cnt_branch, e.cb);
      chk("cnt_taken",  e.cyc, cnt_taken,  e.ct);
      chk("cnt_jump",   e.cyc, cnt_jump,   e.cj);
      chk("small_cnt",  e.cyc, {28'd0, sc_cnt}, {28'd0, e.sc});
    end
  end

  // drive one cycle of inputs just after the edge and queue its expected outputs
  task automatic step(
    input logic r, v, st, input logic [1:0] s, input logic [3:0] b,
    input logic [31:0] pe, im, al,
    input logic [31:0] e_pc, input logic e_fl, e_h, input logic [31:0] e_bad,
    input logic [31:0] e_cb, e_ct, e_cj, input logic [3:0] e_sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; valid_ex = v; stall_pc = st; npc_sel_ex = s; br_type_ex = b;
    pc_ex = pe; imm_ex = im; alu_res_ex = al;
    e.pc = e_pc; e.fl = e_fl; e.hlt = e_h; e.bad = e_bad;
    e.cb = e_cb; e.ct = e_ct; e.cj = e_cj; e.sc = e_sc; e.cyc = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  task automatic idle(input logic st, input logic [31:0] e_pc, input logic e_h, input logic [31:0] e_bad,
                      input logic [31:0] e_cb, e_ct, e_cj, input logic [3:0] e_sc);
    step(1'b0, 1'b0, st, 2'b00, 4'hF, 32'h0, 32'h0, 32'h0, e_pc, 1'b0, e_h, e_bad, e_cb, e_ct, e_cj, e_sc);
  endtask

  initial begin
    rst = 1'b1; valid_ex = 1'b0; stall_pc = 1'b0; npc_sel_ex = 2'b00; br_type_ex = 4'hF;
    pc_ex = '0; imm_ex = '0; alu_res_ex = '0; sc_en = 1'b1;

    // C0: reset with a taken-branch vector present: no flush, no count
    step(1, 1, 0, 2'b01, 4'h0, 32'h100, 32'h4, 32'h0,    32'h0040_0000, 0, 0, 32'h0, 0, 0, 0, 4'd0);
    // C1..C4: free-running sequential fetch
    idle(0, 32'h0040_0000, 0, 0, 0, 0, 0, 4'd0);
    idle(0, 32'h0040_0004, 0, 0, 0, 0, 0, 4'd1);
    idle(0, 32'h0040_0008, 0, 0, 0, 0, 0, 4'd2);
    idle(0, 32'h0040_000C, 0, 0, 0, 0, 0, 4'd3);
    // C5..C8: two stalled cycles hold the PC
    idle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 4'd4);
    idle(1, 32'h0040_0010, 0, 0, 0, 0, 0, 4'd5);
    idle(0, 32'h0040_0010, 0, 0, 0, 0, 0, 4'd6);
    idle(0, 32'h0040_0014, 0, 0, 0, 0, 0, 4'd7);
    // C9: beq taken, pc_ex+(-16), while stalled: redirect wins
    step(0, 1, 1, 2'b01, 4'h0, 32'h0040_0020, 32'hFFFF_FFF0, 32'h0, 32'h0040_0018, 1, 0, 0, 0, 0, 0, 4'd8);
    idle(0, 32'h0040_0010, 0, 0, 1, 1, 0, 4'd9);
    // C11: bne not taken counts a branch only
    step(0, 1, 0, 2'b00, 4'h1, 32'h0, 32'h0, 32'h0,                32'h0040_0014, 0, 0, 0, 1, 1, 0, 4'd10);
    // C12: jalr uses alu result with bit0 cleared, not pc+imm
    step(0, 1, 0, 2'b10, 4'h3, 32'h999, 32'h8, 32'h0040_0101,      32'h0040_0018, 1, 0, 0, 2, 1, 0, 4'd11);
    // C13: same jalr but EX is a bubble
    step(0, 0, 0, 2'b10, 4'h3, 32'h999, 32'h8, 32'h0040_0101,      32'h0040_0100, 0, 0, 0, 2, 1, 1, 4'd12);
    // C14: npc_sel 11 acts as sequential; blt counted, not taken
    step(0, 1, 0, 2'b11, 4'h4, 32'h0040_0000, 32'h40, 32'h0,       32'h0040_0104, 0, 0, 0, 2, 1, 1, 4'd13);
    // C15: aligned jal
    step(0, 1, 0, 2'b10, 4'h2, 32'h0040_0200, 32'h100, 32'h0,      32'h0040_0108, 1, 0, 0, 3, 1, 1, 4'd14);
    idle(1, 32'h0040_0300, 0, 0, 3, 1, 2, 4'd15);
    // C17: misaligned jal traps; small counter has wrapped to 0
    step(0, 1, 0, 2'b10, 4'h2, 32'h0040_0000, 32'h6, 32'h0,        32'h0040_0300, 1, 0, 0, 3, 1, 2, 4'd0);
    // C18: halted: redirect ignored, counters frozen
    step(0, 1, 0, 2'b01, 4'h0, 32'h0040_0020, 32'hFFFF_FFF0, 32'h0, 32'h0040_0300, 0, 1, 32'h0040_0006, 3, 1, 3, 4'd1);
    idle(0, 32'h0040_0300, 1, 32'h0040_0006, 3, 1, 3, 4'd2);
    // C20: reset while halted with a redirect presented
    step(1, 1, 0, 2'b01, 4'h0, 32'h0040_0020, 32'hFFFF_FFF0, 32'h0, 32'h0040_0300, 0, 1, 32'h0040_0006, 3, 1, 3, 4'd3);
    idle(0, 32'h0040_0000, 0, 0, 0, 0, 0, 4'd0);
    idle(0, 32'h0040_0004, 0, 0, 0, 0, 0, 4'd1);

    // let the monitor drain, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
